// File: rtl/sweep_sched_if.sv
// Configuration and status bundle between the SPI register chain and the sweep scheduler.
// The master side drives the sweep configuration; the slave side is the scheduler itself.
interface sweep_sched_if #(
    parameter int W  = 16,
    parameter int DW = 16
);
    logic          i_start;
    logic          i_abort;
    logic [W-1:0]  i_start_step;
    logic [W-1:0]  i_stop_step;
    logic [W-1:0]  i_inc;
    logic [DW-1:0] i_dwell;
    logic          i_loop;
    logic [W-1:0]  o_step;
    logic          o_step_vld;
    logic          o_sine_sel;
    logic          o_busy;
    logic          o_done;

    modport master (
        output i_start, i_abort, i_start_step, i_stop_step, i_inc, i_dwell, i_loop,
        input  o_step, o_step_vld, o_sine_sel, o_busy, o_done
    );

    modport slave (
        input  i_start, i_abort, i_start_step, i_stop_step, i_inc, i_dwell, i_loop,
        output o_step, o_step_vld, o_sine_sel, o_busy, o_done
    );
endinterface

// File: rtl/sweep_sched.sv
// Frequency-sweep scheduler: walks the sine phase step from start to stop, holding each value.
// Optional macro SWEEP_SCHED_PINGPONG_EN makes looping sweeps bounce between the end points.
module sweep_sched #(
    parameter int W  = 16,
    parameter int DW = 16
) (
    input logic          i_clk,
    input logic          i_rst,
    sweep_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  step_q, step_d;
    logic          vld_q, vld_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  startVal_q, startVal_d;
    logic [W-1:0]  stopVal_q, stopVal_d;
    logic [W-1:0]  inc_q, inc_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          loop_q, loop_d;
    logic          up_q, up_d;

    logic [W:0]    sumUp;
    logic [W:0]    diffDn;
    logic          goUp;
    logic [W-1:0]  limit;
    logic          atEnd;
    logic [W-1:0]  nextStep;

    // Carry/borrow in the extra bit marks a step that ran off the end of the number range.
    assign sumUp  = {1'b0, step_q} + {1'b0, inc_q};
    assign diffDn = {1'b0, step_q} - {1'b0, inc_q};

`ifdef SWEEP_SCHED_PINGPONG_EN
    logic          fwd_q, fwd_d;
    logic [W-1:0]  revLimit;
    logic          revEnd;
    logic [W-1:0]  revStep;

    assign goUp     = fwd_q ? up_q : ~up_q;
    assign limit    = fwd_q ? stopVal_q : startVal_q;
    assign revLimit = fwd_q ? startVal_q : stopVal_q;
    assign revStep  = goUp ? diffDn[W-1:0] : sumUp[W-1:0];
    assign revEnd   = goUp ? (diffDn[W] || (diffDn[W-1:0] < revLimit))
                           : (sumUp[W]  || (sumUp[W-1:0]  > revLimit));
`else
    assign goUp  = up_q;
    assign limit = stopVal_q;
`endif

    assign nextStep = goUp ? sumUp[W-1:0] : diffDn[W-1:0];
    assign atEnd    = goUp ? (sumUp[W]  || (sumUp[W-1:0]  > limit))
                           : (diffDn[W] || (diffDn[W-1:0] < limit));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            step_q     <= '0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            startVal_q <= '0;
            stopVal_q  <= '0;
            inc_q      <= '0;
            dwell_q    <= '0;
            loop_q     <= 1'b0;
            up_q       <= 1'b1;
`ifdef SWEEP_SCHED_PINGPONG_EN
            fwd_q      <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            startVal_q <= startVal_d;
            stopVal_q  <= stopVal_d;
            inc_q      <= inc_d;
            dwell_q    <= dwell_d;
            loop_q     <= loop_d;
            up_q       <= up_d;
`ifdef SWEEP_SCHED_PINGPONG_EN
            fwd_q      <= fwd_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        vld_d      = 1'b0;
        cnt_d      = cnt_q;
        startVal_d = startVal_q;
        stopVal_d  = stopVal_q;
        inc_d      = inc_q;
        dwell_d    = dwell_q;
        loop_d     = loop_q;
        up_d       = up_q;
`ifdef SWEEP_SCHED_PINGPONG_EN
        fwd_d      = fwd_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.i_start && !bus.i_abort) begin
                    state_d    = DWELL;
                    startVal_d = bus.i_start_step;
                    stopVal_d  = bus.i_stop_step;
                    inc_d      = (bus.i_inc == '0) ? W'(1) : bus.i_inc;
                    dwell_d    = bus.i_dwell;
                    loop_d     = bus.i_loop;
                    up_d       = (bus.i_start_step <= bus.i_stop_step);
`ifdef SWEEP_SCHED_PINGPONG_EN
                    fwd_d      = 1'b1;
`endif
                    step_d     = bus.i_start_step;
                    vld_d      = 1'b1;
                    cnt_d      = bus.i_dwell;
                end
            end
            DWELL: begin
                if (bus.i_abort) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d = dwell_q;
                    vld_d = 1'b1;
                    if (!atEnd) begin
                        step_d = nextStep;
                    end else if (!loop_q) begin
                        state_d = DONE;
                        vld_d   = 1'b0;
                    end else begin
`ifdef SWEEP_SCHED_PINGPONG_EN
                        // A range too narrow to turn around re-emits the current value.
                        fwd_d = ~fwd_q;
                        if (!revEnd) begin
                            step_d = revStep;
                        end
`else
                        step_d = startVal_q;
`endif
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == DWELL);
        done_d = (state_d == DONE);
    end

    assign bus.o_step     = step_q;
    assign bus.o_step_vld = vld_q;
    assign bus.o_sine_sel = busy_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;

endmodule
